// File: rtl/instr_sequencer.sv
// Fetch/decode/sequence controller: fetches 12-bit instructions over req/ack,
// splits them into alu/register-file fields and pulses reg_we once per instruction.
// Optional INSTR_SEQ_PERF_EN adds a saturating retired-instruction counter (retired_cnt).
module instr_sequencer #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [2:0]         opcode,
  output logic [2:0]         r1,
  output logic [2:0]         r2,
  output logic [2:0]         r3,
  output logic               reg_we,
  output logic               busy,
  output logic               done,
  output logic [PC_W-1:0]    pc
`ifdef INSTR_SEQ_PERF_EN
  ,
  output logic [15:0]        retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 start_acc;

  // start is only honoured while no instruction is in flight
  assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_HALT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_acc) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (instr_q[11:9] == 3'b000) state_d = S_HALT;
        else                         state_d = S_EXEC;
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    reg_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
      end
      S_DECODE, S_EXEC: busy = 1'b1;
      S_WB: begin
        reg_we = 1'b1;
        busy   = 1'b1;
      end
      S_HALT:  done = 1'b1;
      default: ;
    endcase
  end

  // Fields come straight from the instruction register, so they only move on a fetch ack
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign opcode    = instr_q[11:9];
  assign r1        = instr_q[8:6];
  assign r2        = instr_q[5:3];
  assign r3        = instr_q[2:0];

`ifdef INSTR_SEQ_PERF_EN
  logic [15:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (start_acc)
      retired_d = '0;
    else if ((state_q == S_WB) && (retired_q != 16'hFFFF))
      retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a 16-word memory model on the main instance
// and a PC_W=2 instance for the address wrap case.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, imem_req, imem_ack, reg_we, busy, done;
  logic [3:0]  imem_addr, pc;
  logic [11:0] imem_data;
  logic [2:0]  opcode, r1, r2, r3;

  logic        start2, imem_req2, imem_ack2, reg_we2, busy2, done2;
  logic [1:0]  imem_addr2, pc2;
  logic [11:0] imem_data2;
  logic [2:0]  opcode2, r1_2, r2_2, r3_2;
`ifdef INSTR_SEQ_PERF_EN
  logic [15:0] retired, retired2;
`endif

  logic [11:0] mem  [16];
  logic [11:0] mem2 [4];
  int          ack_delay;
  int          wcnt;
  logic        stray_ack;
  int          n_vec = 0;
  int          n_mis = 0;

  instr_sequencer #(.PC_W(4), .INSTR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .opcode(opcode), .r1(r1), .r2(r2), .r3(r3),
    .reg_we(reg_we), .busy(busy), .done(done), .pc(pc)
`ifdef INSTR_SEQ_PERF_EN
    , .retired_cnt(retired)
`endif
  );

  instr_sequencer #(.PC_W(2), .INSTR_W(12)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_data(imem_data2),
    .opcode(opcode2), .r1(r1_2), .r2(r2_2), .r3(r3_2),
    .reg_we(reg_we2), .busy(busy2), .done(done2), .pc(pc2)
`ifdef INSTR_SEQ_PERF_EN
    , .retired_cnt(retired2)
`endif
  );

  // Memory model: ack after ack_delay waiting cycles; junk data whenever not acking
  initial begin
    imem_ack  = 1'b0;
    imem_data = 12'hFFF;
    wcnt      = 0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (wcnt >= ack_delay) begin
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr];
        end else begin
          imem_ack  = 1'b0;
          imem_data = 12'hFFF;
        end
        wcnt++;
      end else begin
        imem_ack  = stray_ack;
        imem_data = 12'hFFF;
        wcnt      = 0;
      end
    end
  end

  initial begin
    imem_ack2  = 1'b0;
    imem_data2 = 12'hFFF;
    forever begin
      @(negedge clk);
      imem_ack2  = imem_req2;
      imem_data2 = imem_req2 ? mem2[imem_addr2] : 12'hFFF;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int pulses;
  int cyc;

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    ack_delay = 0; stray_ack = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 12'h000;
    mem2[0] = 12'h249; mem2[1] = 12'h492; mem2[2] = 12'h6DB; mem2[3] = 12'hE24;
    tick(); tick();

    // Reset state
    chk("rst_req",    32'(imem_req), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_done",   32'(done), 0);
    chk("rst_pc",     32'(pc), 0);
    chk("rst_opcode", 32'({opcode, r1, r2, r3}), 0);
    chk("rst_we",     32'(reg_we), 0);
    rst_n = 1'b1;
    tick();

    // Reset asserted mid-FETCH drops everything immediately
    ack_delay = 1000;
    pulse_start();
    chk("t1_req_fetch", 32'(imem_req), 1);
    chk("t1_busy",      32'(busy), 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t1_req_async", 32'(imem_req), 0);
    chk("t1_busy_async", 32'(busy), 0);
    chk("t1_outs_async", 32'({done, reg_we, pc, opcode, r1, r2, r3}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_idle", 32'({busy, done, imem_req}), 0);

    // Single instruction 001_000_001_010 then HALT
    ack_delay = 0;
    mem[0] = 12'b001_000_001_010;
    mem[1] = 12'h000;
    pulse_start();
    chk("t2_fetch", 32'({imem_req, busy, reg_we}), 32'b110);
    chk("t2_addr",  32'(imem_addr), 0);
    tick();
    chk("t2_dec_fields", 32'({opcode, r1, r2, r3}), 32'b001_000_001_010);
    chk("t2_dec_we",     32'({reg_we, imem_req}), 0);
    tick();
    chk("t2_exec_we",    32'(reg_we), 0);
    chk("t2_exec_fields", 32'({opcode, r1, r2, r3}), 32'b001_000_001_010);
    tick();
    chk("t2_wb_we",  32'(reg_we), 1);
    chk("t2_wb_pc",  32'(pc), 0);
    tick();
    chk("t2_next_we",   32'(reg_we), 0);
    chk("t2_next_pc",   32'(pc), 1);
    chk("t2_next_addr", 32'(imem_addr), 1);
    tick(); tick();
    chk("t2_halt",    32'({done, busy, reg_we}), 32'b100);
    chk("t2_halt_pc", 32'(pc), 1);
    stray_ack = 1'b1;
    tick(); tick(); tick();
    stray_ack = 1'b0;
    chk("t2_stray_ack", 32'({done, opcode, pc}), 32'b1_000_0001);

    // Seven-instruction program then HALT, launched from HALT
    for (int i = 0; i < 7; i++) mem[i] = {3'(i + 1), 3'(i), 3'(7 - i), 3'(i + 1)};
    mem[7] = 12'h000;
    pulse_start();
    chk("t3_restart", 32'({done, imem_req, pc}), 32'b0_1_0000);
`ifdef INSTR_SEQ_PERF_EN
    chk("t3_ret_clr", 32'(retired), 0);
`endif
    pulses = 0;
    cyc    = 0;
    while (!done && cyc < 200) begin
      if (reg_we) begin
        chk("t3_wb_opcode", 32'(opcode), pulses + 1);
        chk("t3_wb_r1",     32'(r1), pulses);
        chk("t3_wb_r2",     32'(r2), 7 - pulses);
        pulses++;
      end
      tick();
      cyc++;
    end
    chk("t3_done",   32'(done), 1);
    chk("t3_cycles", cyc, 30);
    chk("t3_pulses", pulses, 7);
    chk("t3_pc",     32'(pc), 7);
    chk("t3_halt_we", 32'(reg_we), 0);
`ifdef INSTR_SEQ_PERF_EN
    chk("t3_retired", 32'(retired), 7);
`endif

    // Fetch ack delayed by three cycles
    do_reset();
    mem[0] = 12'h5C3;
    ack_delay = 3;
    pulse_start();
    chk("t4_wait0", 32'({imem_req, imem_addr, opcode, r1}), 32'b1_0000_000_000);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t4_wait", 32'({imem_req, imem_addr, opcode, r1, reg_we}), 32'b1_0000_000_000_0);
    end
    tick();
    chk("t4_dec_fields", 32'({opcode, r1, r2, r3}), 32'b010_111_000_011);
    tick();
    chk("t4_exec_we", 32'(reg_we), 0);
    tick();
    chk("t4_wb_we_cyc7", 32'(reg_we), 1);
    tick();
    chk("t4_next", 32'({reg_we, imem_req, pc}), 32'b0_1_0001);

    // start during EXEC ignored, start in HALT restarts
    do_reset();
    ack_delay = 0;
    mem[0] = 12'h20A;
    mem[1] = 12'h000;
    pulse_start();
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_wb_we", 32'(reg_we), 1);
    chk("t6_wb_pc", 32'(pc), 0);
    tick();
    chk("t6_after_wb", 32'({imem_req, pc, imem_addr}), 32'b1_0001_0001);
    tick(); tick();
    chk("t6_halt", 32'({done, busy}), 32'b10);
    pulse_start();
    chk("t6_restart", 32'({done, busy, imem_req, pc}), 32'b0_1_1_0000);

    // PC_W=2 instance wraps 3 -> 0 and refetches address 0
    pulse_start2();
    chk("t5_first", 32'({imem_req2, pc2}), 32'b1_00);
    repeat (12) tick();
    chk("t5_pc3", 32'({imem_req2, pc2, imem_addr2}), 32'b1_11_11);
    repeat (3) tick();
    chk("t5_wb3", 32'({reg_we2, pc2, opcode2}), 32'b1_11_111);
    tick();
    chk("t5_wrap", 32'({imem_req2, pc2, imem_addr2}), 32'b1_00_00);
    tick();
    chk("t5_refetch_op", 32'(opcode2), 1);
    chk("t5_busy", 32'({busy2, done2}), 32'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  task automatic pulse_start2();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
  endtask

endmodule
